// File: rtl/frame_generator_if.sv
// MAC transmit-side bundle: byte stream, data-valid, first-byte ack and MAC configuration strobes.
interface frame_generator_if;
  logic [7:0] mac_tx_data;
  logic       mac_tx_dvld;
  logic       mac_tx_ack;
  logic       conf_tx_en;
  logic       conf_tx_jumbo_en;
  logic       conf_tx_no_gen_crc;

  modport master (
    output mac_tx_data, mac_tx_dvld, conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc,
    input  mac_tx_ack
  );

  modport slave (
    input  mac_tx_data, mac_tx_dvld, conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc,
    output mac_tx_ack
  );
endinterface

// File: rtl/frame_generator.sv
// Builds Ethernet frames (dst, src, type, seq[, timestamp], fill) and streams them byte-wise to the MAC.
// Optional payload timestamp: define FRAME_GEN_TIMESTAMP_EN.
module frame_generator #(
  parameter int unsigned PAYLOAD_MAX = 9000,
  parameter int unsigned PAYLOAD_MIN = 46,
  parameter int unsigned LEN_W       = 14,
  parameter int unsigned GAP_W       = 16
) (
  input  logic              tx_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       burst_count,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic [47:0]       dst_mac,
  input  logic [47:0]       src_mac,
  input  logic [15:0]       eth_type,
  output logic              busy,
  output logic [31:0]       frames_sent,
  frame_generator_if.master mac
);
  localparam int unsigned IDX_W = LEN_W + 1;
  localparam int unsigned HDR_B = 14;
`ifdef FRAME_GEN_TIMESTAMP_EN
  localparam int unsigned HEAD_B = 8;
`else
  localparam int unsigned HEAD_B = 4;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_ACK, S_SEND, S_GAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_data, w_data_nxt;
  logic               r_dvld, w_dvld_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_en, w_en_nxt;
  logic               r_jumbo;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt, r_last_idx;
  logic [GAP_W-1:0]   r_gap, r_gap_cnt, w_gap_cnt_nxt;
  logic [15:0]        r_burst, w_burst_nxt;
  logic               r_cont, r_last, w_last_nxt;
  logic [31:0]        r_seq, w_seq_nxt, r_frames, w_frames_nxt;
  logic [47:0]        r_dst, r_src;
  logic [15:0]        r_type;
  logic               w_latch;
  logic [LEN_W-1:0]   w_lp;
  logic [IDX_W-1:0]   w_idx_inc, w_pidx;
  logic [3:0]         w_hsel;
  logic [2:0]         w_psel;
  logic [7:0]         w_byte;
  logic [8*HDR_B-1:0] w_hdr;
  logic [8*HEAD_B-1:0] w_phead;

  // Effective payload length: pad short requests, clamp long ones.
  always_comb begin
    w_lp = payload_len;
    if (payload_len < LEN_W'(PAYLOAD_MIN))      w_lp = LEN_W'(PAYLOAD_MIN);
    else if (payload_len > LEN_W'(PAYLOAD_MAX)) w_lp = LEN_W'(PAYLOAD_MAX);
  end

`ifdef FRAME_GEN_TIMESTAMP_EN
  logic [31:0] r_ts_cnt, r_ts;
  logic        w_ts_take;
  assign w_ts_take = (r_state == S_WAIT_ACK) && mac.mac_tx_ack;

  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ts_cnt <= '0;
      r_ts     <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 32'd1;
      if (w_ts_take) r_ts <= r_ts_cnt;
    end
  end
  assign w_phead = {r_seq, r_ts};
`else
  assign w_phead = r_seq;
`endif

  // Byte to present next, selected from the frame index that follows the current one.
  assign w_hdr     = {r_dst, r_src, r_type};
  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_pidx    = w_idx_inc - IDX_W'(HDR_B);
  assign w_hsel    = 4'(HDR_B - 1) - 4'(w_idx_inc);
  assign w_psel    = 3'(HEAD_B - 1) - 3'(w_pidx);

  always_comb begin
    w_byte = 8'(w_pidx - IDX_W'(HEAD_B));
    if (w_idx_inc < IDX_W'(HDR_B))      w_byte = 8'(w_hdr >> {w_hsel, 3'b000});
    else if (w_pidx < IDX_W'(HEAD_B))   w_byte = 8'(w_phead >> {w_psel, 3'b000});
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_dvld_nxt    = r_dvld;
    w_en_nxt      = r_en;
    w_idx_nxt     = r_idx;
    w_gap_cnt_nxt = r_gap_cnt;
    w_burst_nxt   = r_burst;
    w_last_nxt    = r_last;
    w_seq_nxt     = r_seq;
    w_frames_nxt  = r_frames;
    w_latch       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_latch     = 1'b1;
          w_en_nxt    = 1'b1;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_WAIT_ACK;
        w_dvld_nxt  = 1'b1;
        w_data_nxt  = r_dst[47:40];
        w_idx_nxt   = '0;
      end
      S_WAIT_ACK: begin
        if (mac.mac_tx_ack) begin
          w_state_nxt = S_SEND;
          w_data_nxt  = w_byte;
          w_idx_nxt   = w_idx_inc;
        end
      end
      S_SEND: begin
        if (r_idx == r_last_idx) begin
          w_state_nxt   = S_GAP;
          w_dvld_nxt    = 1'b0;
          w_data_nxt    = '0;
          w_seq_nxt     = r_seq + 32'd1;
          w_frames_nxt  = r_frames + 32'd1;
          w_gap_cnt_nxt = r_gap - GAP_W'(1);
          w_burst_nxt   = r_cont ? r_burst : r_burst - 16'd1;
          w_last_nxt    = stop || (!r_cont && (r_burst == 16'd1));
        end else begin
          w_data_nxt = w_byte;
          w_idx_nxt  = w_idx_inc;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          if (r_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT_ACK;
            w_dvld_nxt  = 1'b1;
            w_data_nxt  = r_dst[47:40];
            w_idx_nxt   = '0;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_dvld     <= 1'b0;
      r_busy     <= 1'b0;
      r_en       <= 1'b0;
      r_jumbo    <= 1'b0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      r_burst    <= '0;
      r_cont     <= 1'b0;
      r_last     <= 1'b0;
      r_seq      <= '0;
      r_frames   <= '0;
      r_dst      <= '0;
      r_src      <= '0;
      r_type     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_dvld    <= w_dvld_nxt;
      r_busy    <= w_busy_nxt;
      r_en      <= w_en_nxt;
      r_idx     <= w_idx_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_burst   <= w_burst_nxt;
      r_last    <= w_last_nxt;
      r_seq     <= w_seq_nxt;
      r_frames  <= w_frames_nxt;
      if (w_latch) begin
        r_dst      <= dst_mac;
        r_src      <= src_mac;
        r_type     <= eth_type;
        r_jumbo    <= (w_lp > LEN_W'(1500));
        r_last_idx <= IDX_W'(w_lp) + IDX_W'(HDR_B - 1);
        r_gap      <= (gap_cycles == '0) ? GAP_W'(1) : gap_cycles;
        r_burst    <= burst_count;
        r_cont     <= (burst_count == 16'd0);
      end
    end
  end

  assign busy                   = r_busy;
  assign frames_sent            = r_frames;
  assign mac.mac_tx_data        = r_data;
  assign mac.mac_tx_dvld        = r_dvld;
  assign mac.conf_tx_en         = r_en;
  assign mac.conf_tx_jumbo_en   = r_jumbo;
  assign mac.conf_tx_no_gen_crc = 1'b0;
endmodule

// File: tb/tb_frame_generator.sv
// Self-checking bench for frame_generator: vector table, hand-written corner sequences and random bursts.
module tb_frame_generator;
  localparam int unsigned LEN_W = 14;
  localparam int unsigned GAP_W = 16;
`ifdef FRAME_GEN_TIMESTAMP_EN
  localparam int unsigned TB_HEAD_B = 8;
`else
  localparam int unsigned TB_HEAD_B = 4;
`endif

  logic              tx_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start, stop;
  logic [15:0]       burst_count;
  logic [LEN_W-1:0]  payload_len;
  logic [GAP_W-1:0]  gap_cycles;
  logic [47:0]       dst_mac, src_mac;
  logic [15:0]       eth_type;
  logic              busy;
  logic [31:0]       frames_sent;

  frame_generator_if mac_if ();

  frame_generator dut (
    .tx_clk      (tx_clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .burst_count (burst_count),
    .payload_len (payload_len),
    .gap_cycles  (gap_cycles),
    .dst_mac     (dst_mac),
    .src_mac     (src_mac),
    .eth_type    (eth_type),
    .busy        (busy),
    .frames_sent (frames_sent),
    .mac         (mac_if)
  );

  always #5 tx_clk = ~tx_clk;

  // Cycles since reset release; used as the expected timestamp.
  logic [31:0] tb_cyc;
  always @(posedge tx_clk or negedge reset_n)
    if (!reset_n) tb_cyc <= '0;
    else          tb_cyc <= tb_cyc + 32'd1;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_seq = '0;
  logic [31:0] m_frames = '0;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    int unsigned len;
    int unsigned burst;
    int unsigned gap;
    int unsigned ack_dly;
    int unsigned exp_len;
    int unsigned exp_gap;
    logic        exp_jumbo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned eff_len(input int unsigned len);
    if (len < 46)   return 46;
    if (len > 9000) return 9000;
    return len;
  endfunction

  // Reference frame built directly from the layout rules.
  function automatic byte_q_t build_frame(input logic [47:0] d, input logic [47:0] s,
                                          input logic [15:0] t, input int unsigned lp,
                                          input logic [31:0] seq, input logic [31:0] ts);
    byte_q_t q;
    q = {};
    for (int i = 5; i >= 0; i--) q.push_back(d[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(s[i*8 +: 8]);
    q.push_back(t[15:8]);
    q.push_back(t[7:0]);
    for (int i = 3; i >= 0; i--) q.push_back(seq[i*8 +: 8]);
    if (TB_HEAD_B == 8)
      for (int i = 3; i >= 0; i--) q.push_back(ts[i*8 +: 8]);
    for (int k = 0; k < int'(lp - TB_HEAD_B); k++) q.push_back(8'(k));
    return q;
  endfunction

  // Starts one burst with the current inputs and checks every frame, gap and the return to idle.
  task automatic run_burst(input string tag, input int unsigned frames_exp, input int unsigned ack_dly,
                           input int unsigned exp_len, input int unsigned exp_gap, input logic exp_jumbo,
                           input int stop_at, input bit poke_start, input int unsigned ack_hold);
    byte_q_t got, expq;
    int cyc, bad;
    logic [31:0] ts;
    int unsigned lp;
    lp = eff_len(int'(payload_len));
    @(negedge tx_clk); start = 1'b1;
    @(negedge tx_clk); start = 1'b0;
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    check({tag, " dvld in load"}, 64'(mac_if.mac_tx_dvld), 64'd0);
    @(negedge tx_clk);
    check({tag, " dvld two cycles after start"}, 64'(mac_if.mac_tx_dvld), 64'd1);
    check({tag, " conf_tx_en"}, 64'(mac_if.conf_tx_en), 64'd1);
    check({tag, " conf_tx_jumbo_en"}, 64'(mac_if.conf_tx_jumbo_en), 64'(exp_jumbo));
    for (int f = 0; f < int'(frames_exp); f++) begin
      cyc = 0;
      while (!mac_if.mac_tx_dvld && cyc < 1000) begin @(negedge tx_clk); cyc++; end
      if (cyc >= 1000) begin
        check({tag, " timeout waiting for dvld"}, 64'd1, 64'd0);
        return;
      end
      repeat (ack_dly) @(negedge tx_clk);
      check({tag, " byte0 held before ack"}, {mac_if.mac_tx_dvld, mac_if.mac_tx_data},
            {1'b1, dst_mac[47:40]});
      got = {};
      got.push_back(mac_if.mac_tx_data);
      ts = tb_cyc;
      mac_if.mac_tx_ack = 1'b1;
      @(negedge tx_clk);
      cyc = 0;
      while (mac_if.mac_tx_dvld && cyc < 20000) begin
        got.push_back(mac_if.mac_tx_data);
        mac_if.mac_tx_ack = (cyc + 1 < int'(ack_hold));
        if (f == stop_at && cyc == 20) stop = 1'b1;
        start = poke_start && (f == 1) && (cyc == 30);
        @(negedge tx_clk);
        cyc++;
      end
      mac_if.mac_tx_ack = 1'b0;
      start = 1'b0;
      expq = build_frame(dst_mac, src_mac, eth_type, lp, m_seq, ts);
      check($sformatf("%s frame%0d length", tag, f), 64'(got.size()), 64'(exp_len));
      bad = -1;
      for (int k = 0; k < got.size() && k < expq.size(); k++)
        if (bad < 0 && got[k] !== expq[k]) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s frame%0d byte %0d: got %02h expected %02h", tag, f, bad, got[bad], expq[bad]);
      end
      m_seq++;
      m_frames++;
      check($sformatf("%s frame%0d frames_sent", tag, f), 64'(frames_sent), 64'(m_frames));
      cyc = 0;
      while (!mac_if.mac_tx_dvld && busy && cyc < 70000) begin @(negedge tx_clk); cyc++; end
      check($sformatf("%s frame%0d gap", tag, f), 64'(cyc), 64'(exp_gap));
      if (f == int'(frames_exp) - 1)
        check({tag, " idle after burst"}, {62'd0, busy, mac_if.mac_tx_dvld}, 64'd0);
      else
        check($sformatf("%s frame%0d next frame begins", tag, f), 64'(mac_if.mac_tx_dvld), 64'd1);
    end
    stop = 1'b0;
  endtask

  vec_t tbl[7];

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    byte_q_t dummy;
    int unsigned lp_r;
    start = 1'b0;
    stop = 1'b0;
    mac_if.mac_tx_ack = 1'b0;
    burst_count = 16'd1;
    payload_len = LEN_W'(46);
    gap_cycles = GAP_W'(12);
    dst_mac = 48'hFFFF_FFFF_FFFF;
    src_mac = 48'h004E_4632_4300;
    eth_type = 16'h0800;

    #12;
    check("reset outputs", {mac_if.mac_tx_data, mac_if.mac_tx_dvld, mac_if.conf_tx_en,
                            mac_if.conf_tx_jumbo_en, mac_if.conf_tx_no_gen_crc, busy},
          64'd0);
    check("reset frames_sent", 64'(frames_sent), 64'd0);
    @(negedge tx_clk); reset_n = 1'b1;

    tbl[0] = '{46,    1, 12, 3, 60,   12, 1'b0};
    tbl[1] = '{10,    1, 12, 0, 60,   12, 1'b0};
    tbl[2] = '{2000,  1, 4,  1, 2014, 4,  1'b1};
    tbl[3] = '{12000, 1, 0,  2, 9014, 1,  1'b1};
    tbl[4] = '{1500,  2, 1,  1, 1514, 1,  1'b0};
    tbl[5] = '{1501,  1, 3,  0, 1515, 3,  1'b1};
    tbl[6] = '{46,    3, 5,  2, 60,   5,  1'b0};
    for (int i = 0; i < 7; i++) begin
      payload_len = LEN_W'(tbl[i].len);
      burst_count = 16'(tbl[i].burst);
      gap_cycles  = GAP_W'(tbl[i].gap);
      run_burst($sformatf("vec%0d", i), tbl[i].burst, tbl[i].ack_dly, tbl[i].exp_len,
                tbl[i].exp_gap, tbl[i].exp_jumbo, -1, 1'b0, 1);
    end

    // Continuous burst stopped during frame 4, with a start pulse while busy and ack held two cycles.
    payload_len = LEN_W'(60);
    burst_count = 16'd0;
    gap_cycles  = GAP_W'(2);
    run_burst("stop", 4, 1, 74, 2, 1'b0, 3, 1'b1, 2);
    repeat (20) @(negedge tx_clk);
    check("stop stays idle dvld", 64'(mac_if.mac_tx_dvld), 64'd0);
    check("stop stays idle frames", 64'(frames_sent), 64'(m_frames));

    // Reset pulled low mid-payload.
    payload_len = LEN_W'(100);
    burst_count = 16'd1;
    @(negedge tx_clk); start = 1'b1;
    @(negedge tx_clk); start = 1'b0;
    @(negedge tx_clk);
    mac_if.mac_tx_ack = 1'b1;
    @(negedge tx_clk); mac_if.mac_tx_ack = 1'b0;
    repeat (30) @(negedge tx_clk);
    check("pre-reset dvld", 64'(mac_if.mac_tx_dvld), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset data/dvld", {mac_if.mac_tx_data, mac_if.mac_tx_dvld}, 64'd0);
    check("async reset busy/conf", {busy, mac_if.conf_tx_en, mac_if.conf_tx_jumbo_en}, 64'd0);
    check("async reset frames_sent", 64'(frames_sent), 64'd0);
    m_seq = '0;
    m_frames = '0;
    @(negedge tx_clk); reset_n = 1'b1;
    payload_len = LEN_W'(46);
    gap_cycles  = GAP_W'(3);
    run_burst("post-reset", 1, 1, 60, 3, 1'b0, -1, 1'b0, 1);

    // Random bursts against the reference model.
    for (int r = 0; r < 6; r++) begin
      dst_mac     = {$urandom(), $urandom()};
      src_mac     = {$urandom(), $urandom()};
      eth_type    = 16'($urandom());
      payload_len = LEN_W'($urandom_range(0, 1600));
      gap_cycles  = GAP_W'($urandom_range(0, 9));
      burst_count = 16'($urandom_range(1, 3));
      lp_r = eff_len(int'(payload_len));
      run_burst($sformatf("rand%0d", r), int'(burst_count), $urandom_range(0, 4), 14 + lp_r,
                (gap_cycles == 0) ? 1 : int'(gap_cycles), (lp_r > 1500), -1, 1'b0,
                $urandom_range(1, 2));
    end

    check("conf_tx_no_gen_crc", 64'(mac_if.conf_tx_no_gen_crc), 64'd0);
    dummy = {};
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_generator.md
# frame_generator

Parametrised successor to the fixed-ARP transmit source in the delay tester. It builds Ethernet frames on the fly and streams them byte-wise into the MAC TX interface. Destination/source MAC, EtherType, payload length, inter-frame gap and burst count are all programmable. Each payload carries a sequence number so the receive side can measure loss and delay.

## Interface
- PAYLOAD_MAX, default 9000: largest payload length accepted, in bytes; longer requests are clamped to it.
- PAYLOAD_MIN, default 46: smallest payload length; shorter requests are padded up to it.
- LEN_W, default 14: width of payload_len.
- GAP_W, default 16: width of gap_cycles.
- tx_clk  in  1  transmit clock; every register is clocked on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that starts a burst; ignored while busy=1.
- stop  in  1  level; the current frame completes, then the block returns to IDLE.
- burst_count  in  16  frames per burst; 0 means continuous until stop.
- payload_len  in  LEN_W  payload bytes per frame, sampled on start.
- gap_cycles  in  GAP_W  dvld-low cycles between frames, sampled on start; 0 is treated as 1.
- dst_mac, src_mac  in  48  sampled on start.
- eth_type  in  16  sampled on start.
- busy  out  1  high from the cycle after an accepted start until the block is back in IDLE.
- frames_sent  out  32  count of completed frames, wraps modulo 2^32.
- conf_tx_en  out  1  set on the first accepted start and held until reset.
- conf_tx_jumbo_en  out  1  high while the latched payload length is greater than 1500.
- conf_tx_no_gen_crc  out  1  constant 0; the MAC appends the FCS.
- mac_tx_data  out  8  registered transmit byte.
- mac_tx_dvld  out  1  registered data-valid.
- mac_tx_ack  in  1  MAC accepted the first byte of the frame.

## Operation
- Frame layout, in transmit order, most significant byte first:
  - dst_mac (6 bytes), src_mac (6 bytes), eth_type (2 bytes);
  - payload: seq (4 bytes), optional timestamp (4 bytes), then fill bytes.
  - Fill byte k (k counted from the first fill byte) = k mod 256.
- Effective payload length Lp = clamp(payload_len, PAYLOAD_MIN, PAYLOAD_MAX). Frame length L = 14 + Lp.
- seq is a 32-bit counter, reset to 0. It increments as each frame completes and is not cleared between bursts.
- States:
  - IDLE: on start, go to LOAD.
  - LOAD: latch the configuration, then go to WAIT_ACK.
  - WAIT_ACK: on mac_tx_ack, go to SEND.
  - SEND: after byte L-1 is presented, go to GAP.
  - GAP: after gap_cycles cycles, go to IDLE if stop is high or the burst is complete; otherwise go to WAIT_ACK.
- In WAIT_ACK: dvld=1 and data=dst_mac[47:40], held until ack.
- In SEND: one new byte every cycle, with no backpressure after ack (MAC contract).
- Burst counter: loaded in LOAD, decremented as each frame completes, and ignored when burst_count=0.
- stop: sampled only when a frame completes; it never truncates a frame.
- A start that arrives while busy=1 is dropped.

## Timing
- Reset values: mac_tx_data=0, mac_tx_dvld=0, all conf_* outputs = 0, busy=0, frames_sent=0, seq=0, state=IDLE.
- Reset asserted mid-frame: every output takes its reset value asynchronously. The frame is abandoned and frames_sent is not incremented.
- start at edge n: busy=1 and state LOAD from n+1; dvld=1 with byte 0 from n+2.
- Ack sampled high at edge a: byte 1 appears at a+1 and byte i at a+i. Byte L-1 is at a+L-1, and dvld=0 at a+L.
- frames_sent and seq increment at edge a+L.
- Gap: dvld stays low for exactly max(gap_cycles,1) cycles. The next frame's byte 0 is then presented with dvld=1.
- ack held high beyond the first cycle is ignored until the next WAIT_ACK.
- seq wraps from 0xFFFFFFFF to 0.

## Configuration
- FRAME_GEN_TIMESTAMP_EN defined: a free-running 32-bit tx_clk cycle counter (reset 0, wraps) is captured at the edge where ack is sampled. The captured value is inserted as payload bytes 4..7, and fill starts at payload byte 8.
- FRAME_GEN_TIMESTAMP_EN undefined: no timestamp counter exists, and fill starts at payload byte 4.
- Lp and L are the same in both builds.

## Test plan
- Reset, then start with dst=FFFFFFFFFFFF, src=004E46324300, type=0x0800, len=46, burst=1, gap=12, ack 3 cycles after dvld:
  - expect 60 bytes FF×6, 00 4E 46 32 43 00, 08 00, 00 00 00 00, then fill;
  - expect dvld low afterwards, frames_sent=1, busy low after 12 gap cycles.
- len=10: frame padded to 60 bytes. len=2000: conf_tx_jumbo_en=1 and 2014 bytes are sent.
- burst=3, gap=5: three frames with seq 0, 1, 2 and exactly 5 dvld-low cycles between them; frames_sent=3.
- burst=0, stop raised mid-frame 4: frame 4 completes in full, then IDLE. A start pulsed while busy has no effect.
- reset_n pulled low mid-payload: dvld=0 and data=0 immediately. A new start then sends seq=0.
- FRAME_GEN_TIMESTAMP_EN build: payload bytes 4..7 equal the cycle count at the edge where ack was sampled, and fill begins 00 01 02 at payload byte 8.
